// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES slices of WIDTH/STAGES bits.
// Each stage adds one slice and registers its carry for the next stage.
// Throughput is one add per clock and latency is STAGES cycles. A stall at the
// output freezes every stage.
// Optional build macro PIPELINED_ADDER_OVF_EN adds the registered signed-overflow
// output ovf.
// Legal parameters: WIDTH % STAGES == 0 and STAGES >= 1.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int SLICE = WIDTH / STAGES;

   // A single advance enable moves the whole pipe. It depends only on the
   // output handshake, so in_ready never looks at in_valid.
   logic adv_s;
   assign adv_s    = !g_stg[STAGES-1].vld_q | out_ready;
   assign in_ready = adv_s;

   genvar k;
   for (k = 0; k < STAGES; k++) begin : g_stg
      // Operand bits still unprocessed when they enter this stage.
      localparam int IN_W  = WIDTH - k * SLICE;
      // Low sum bits that are complete once this stage has run.
      localparam int RES_W = (k + 1) * SLICE;

      logic [IN_W-1:0]  src_a_s;
      logic [IN_W-1:0]  src_b_s;
      logic             src_c_s;
      logic             src_v_s;
      logic [SLICE:0]   slice_s;
      logic [RES_W-1:0] res_d;
      logic [RES_W-1:0] res_q;
      logic             cy_q;
      logic             vld_q;

      if (k == 0) begin : g_head
         assign src_a_s = a;
         assign src_b_s = b;
         assign src_c_s = cin;
         assign src_v_s = in_valid;
         assign res_d   = slice_s[SLICE-1:0];
      end else begin : g_body
         assign src_a_s = g_stg[k-1].g_fwd.opa_q;
         assign src_b_s = g_stg[k-1].g_fwd.opb_q;
         assign src_c_s = g_stg[k-1].cy_q;
         assign src_v_s = g_stg[k-1].vld_q;
         assign res_d   = {slice_s[SLICE-1:0], g_stg[k-1].res_q};
      end

      // The lowest remaining slice is always the one this stage adds.
      assign slice_s = {1'b0, src_a_s[SLICE-1:0]}
                     + {1'b0, src_b_s[SLICE-1:0]}
                     + {{SLICE{1'b0}}, src_c_s};

      // Stage valid, carry and partial sum. Data loads only with a valid beat.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            res_q <= {RES_W{1'b0}};
         end else if (adv_s) begin
            vld_q <= src_v_s;
            if (src_v_s) begin
               cy_q  <= slice_s[SLICE];
               res_q <= res_d;
            end
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [IN_W-SLICE-1:0] opa_q;
         logic [IN_W-SLICE-1:0] opb_q;

         // Forward only the operand slices that later stages still need.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               opa_q <= {(IN_W-SLICE){1'b0}};
               opb_q <= {(IN_W-SLICE){1'b0}};
            end else if (adv_s && src_v_s) begin
               opa_q <= src_a_s[IN_W-1:SLICE];
               opb_q <= src_b_s[IN_W-1:SLICE];
            end
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].vld_q;
   assign sum       = g_stg[STAGES-1].res_q;
   assign cout      = g_stg[STAGES-1].cy_q;

`ifdef PIPELINED_ADDER_OVF_EN
   // The carry into the MSB equals a^b^sum at the MSB. Signed overflow is that
   // carry XOR the carry out of the MSB.
   logic ovf_d;
   logic ovf_q;
   assign ovf_d = g_stg[STAGES-1].src_a_s[SLICE-1] ^ g_stg[STAGES-1].src_b_s[SLICE-1]
                ^ g_stg[STAGES-1].slice_s[SLICE-1] ^ g_stg[STAGES-1].slice_s[SLICE];

   // Overflow flag is registered with the final sum and holds through stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (adv_s && g_stg[STAGES-1].src_v_s) begin
         ovf_q <= ovf_d;
      end
   end
   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed + random bench for pipelined_adder with a scoreboard queue.
module tb_pipelined_adder;

   localparam int W = 32;
   localparam int S = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef PIPELINED_ADDER_OVF_EN
   logic         ovf;
`endif

   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Scoreboard entries are {ovf, cout, sum}.
   logic [W+1:0] sb[$];

   logic         acc;
   logic         samp_ready;
   logic         samp_valid;
   logic [W-1:0] samp_sum;
   logic         samp_cout;
   int           cyc_ctr;
   int           first_vld;
   int           vld_seen;
   int           ready_low;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc);
      logic [W:0] s;
      logic       v;
      s = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      v = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
      return {v, s};
   endfunction

   // Called one time unit after a rising edge, with inputs already driven.
   task automatic run_cycle();
      logic [W+1:0] e;
      #1;
      samp_ready = in_ready;
      samp_valid = out_valid;
      samp_sum   = sum;
      samp_cout  = cout;
      acc        = in_valid && in_ready;
      if (!in_ready) ready_low++;
      if (out_valid) begin
         vld_seen++;
         if (first_vld < 0) first_vld = cyc_ctr;
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_out", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            check("sum", 64'(sum), 64'(e[W-1:0]));
            check("cout", 64'(cout), 64'(e[W]));
`ifdef PIPELINED_ADDER_OVF_EN
            check("ovf", 64'(ovf), 64'(e[W+1]));
`endif
         end
      end
      if (acc) sb.push_back(model(a, b, cin));
      cyc_ctr++;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
      a        = ta;
      b        = tb_;
      cin      = tc;
      in_valid = 1'b1;
      acc      = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) run_cycle();
      if (!acc) check("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() > 0; i++) run_cycle();
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      logic [W-1:0] held;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = 32'd0;
      b         = 32'd0;
      cin       = 1'b0;
      cyc_ctr   = 0;
      first_vld = -1;
      vld_seen  = 0;
      ready_low = 0;
      #3;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Wrap to zero with carry out; latency and single-cycle valid pulse.
      cyc_ctr   = 0;
      first_vld = -1;
      vld_seen  = 0;
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) run_cycle();
      check("lat_first_valid", 64'(first_vld), 64'(S));
      check("lat_valid_cycles", 64'(vld_seen), 64'd1);
      check("wrap_sum", 64'(sb.size()), 64'd0);

      // Carry rippling through every stage boundary.
      send(32'h00FF_FFFF, 32'h0000_0000, 1'b1);
      drain();

      // Signed overflow corner cases (sum/cout checked in every build).
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      send(32'h8000_0000, 32'h8000_0000, 1'b0);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      send(32'h0000_0000, 32'h0000_0000, 1'b0);
      drain();

      // 100 back-to-back random beats with no backpressure.
      ready_low = 0;
      for (int i = 0; i < 100; i++)
         send($urandom, $urandom, 1'($urandom_range(0, 1)));
      check("stream_in_ready_low", 64'(ready_low), 64'd0);
      drain();

      // Backpressure: fill the pipe, stall 5 cycles with a beat waiting.
      for (int i = 0; i < S; i++) send(32'h1000_0000 + 32'(i), 32'h0000_0100, 1'b1);
      out_ready = 1'b0;
      a         = 32'hA5A5_A5A5;
      b         = 32'h5A5A_5A5A;
      cin       = 1'b1;
      held      = sum;
      for (int i = 0; i < 5; i++) begin
         run_cycle();
         check("stall_in_ready", 64'(samp_ready), 64'd0);
         check("stall_out_valid", 64'(samp_valid), 64'd1);
         check("stall_sum_held", 64'(samp_sum), 64'(held));
         check("stall_no_accept", 64'(acc), 64'd0);
      end
      out_ready = 1'b1;
      send(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
      send(32'h0000_0007, 32'h0000_0009, 1'b0);
      drain();

      // Reset with three beats in flight.
      send(32'h0000_0011, 32'h0000_0022, 1'b0);
      send(32'h0000_0033, 32'h0000_0044, 1'b1);
      send(32'hFFFF_0000, 32'h0001_0000, 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_sum", 64'(sum), 64'd0);
      check("midrst_cout", 64'(cout), 64'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      vld_seen = 0;
      for (int i = 0; i < 2 * S; i++) run_cycle();
      check("post_rst_no_valid", 64'(vld_seen), 64'd0);
      send(32'h1234_5678, 32'h1111_1111, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's ripple-carry adders.
- Adds two WIDTH-bit operands plus carry-in, SLICE = WIDTH/STAGES bits per stage, registering the carry between stages.
- Throughput is one add per clock; latency is STAGES cycles; output backpressure is supported.
- Sits on datapath ALU and accumulator paths where a full-width ripple chain misses timing.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- STAGES, 4, pipeline stage count; WIDTH % STAGES must be 0; STAGES >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (asynchronous, rst_n=0): all stage valid bits, out_valid, sum, cout and all pipeline data registers clear to 0. Release is synchronous to the next clk edge.
- Global advance: adv = !out_valid | out_ready. in_ready = adv, combinational, with no dependence on in_valid.
- Accept: a beat is accepted when in_valid & in_ready. Stage 0 captures the sum of slice 0 (a[SLICE-1:0] + b[SLICE-1:0] + cin), its carry, and the unprocessed upper slices of a and b.
- Stage k (1..STAGES-1), on adv: adds slice k of the forwarded operands plus the registered carry of stage k-1. It passes the already-computed low sum slices forward unchanged and drops the consumed operand slices.
- Valid bits shift one stage per cycle when adv=1. A bubble (no accepted beat) enters stage 0 as valid=0.
- The final stage register drives sum, cout and out_valid directly (registered outputs, no combinational path from a or b).
- Latency: a beat accepted at edge N has out_valid=1 after edge N+STAGES-1 when adv stays 1.
- Stall: when out_valid=1 and out_ready=0, every stage register holds, including valid bits and carries, and in_ready=0. Results are never lost or duplicated.
- Simultaneous out_ready=1 and in_valid=1 while full: the pipeline advances and accepts in the same cycle, sustaining 1 beat/cycle.
- STAGES=1: degenerates to a single registered full-width adder with 1-cycle latency.
- Overflow wrap: sum wraps mod 2^WIDTH and cout reports the carry.
- Reset mid-operation: all in-flight beats are discarded and no out_valid pulse follows reset release.
- in_valid while in_ready=0: ignored. The source must hold the beat.

Optional Feature:
- Macro: PIPELINED_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), the two's-complement signed overflow of a + b + cin. ovf = carry into MSB XOR carry out of MSB, computed in the final stage. ovf is registered alongside sum, resets to 0, and holds during stall.
- Undefined: the port does not exist and no extra logic is built.

Test Plan:
- WIDTH=32, STAGES=4: a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> after 4 cycles sum=0x00000000, cout=1, out_valid high for exactly 1 cycle.
- Carry ripple across every stage boundary: a=0x00FFFFFF, b=0, cin=1 -> sum=0x01000000, cout=0.
- Stream 100 random beats with out_ready=1 -> in_ready constantly 1, one result per cycle in order, each matching the reference model.
- Backpressure: fill the pipe, drop out_ready for 5 cycles, then raise it -> in_ready=0 during the stall, sum held stable, no beats lost or repeated, order preserved.
- Reset asserted with 3 beats in flight -> outputs 0 immediately; after release, no out_valid until new beats enter.
- PIPELINED_ADDER_OVF_EN defined: a=0x7FFFFFFF, b=1 -> sum=0x80000000, ovf=1, cout=0. a=0xFFFFFFFF, b=1 -> ovf=0, cout=1.
